// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-master SRAM arbiter: FSM states and master indices.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_M0 = 2'd1,
    RD_M1 = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic state_t rd_state(input logic master);
    return (master == M1) ? RD_M1 : RD_M0;
  endfunction

endpackage

// File: rtl/sram_arbiter_arb_grant2.sv
// Combinational two-way grant: single requester wins outright, contention resolved by pointer.
module arb_grant2
  import sram_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       ptr,
  input  logic       flush,
  output logic [1:0] gnt
);

  // ptr holds the last-granted master; the other one wins a tie
  always_comb begin
    gnt = '0;
    if (!flush) begin
      if (req0 && req1) gnt = (ptr == M0) ? 2'b10 : 2'b01;
      else              gnt = {req1, req0};
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master (m0 instr / m1 data) single-port SRAM arbiter with pipelined reads.
// Optional round-robin arbitration via macro SRAM_ARB_RR_EN (default: m1 fixed priority).
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                m0_req,
  input  logic [DATA_W/8-1:0] m0_wen,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic                m1_req,
  input  logic [DATA_W/8-1:0] m1_wen,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m0_gnt,
  output logic                m1_gnt,
  output logic                m0_rvalid,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic                stallreq
);

  logic [1:0] gnt;
  logic       last_gnt;
  logic       m0_rd;
  logic       m1_rd;
  state_t     state;

  arb_grant2 u_grant (
    .req0  (m0_req & ~rst),
    .req1  (m1_req & ~rst),
    .ptr   (last_gnt),
    .flush (flush),
    .gnt   (gnt)
  );

  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];
  assign sram_en = |gnt;

  always_comb begin
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (gnt[1]) begin
      sram_wen   = m1_wen;
      sram_addr  = m1_addr;
      sram_wdata = m1_wdata;
    end else if (gnt[0]) begin
      sram_wen   = m0_wen;
      sram_addr  = m0_addr;
      sram_wdata = m0_wdata;
    end
  end

  assign stallreq = (m0_req & ~m0_gnt) | (m1_req & ~m1_gnt);

  assign m0_rd = m0_gnt && (m0_wen == '0);
  assign m1_rd = m1_gnt && (m1_wen == '0);

  // A new grant may be issued from any state, so reads stream one per cycle
  always_ff @(posedge clk) begin
    if (rst)        state <= IDLE;
    else if (m1_rd) state <= rd_state(M1);
    else if (m0_rd) state <= rd_state(M0);
    else            state <= IDLE;
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst)       last_gnt <= M0;
    else if (|gnt) last_gnt <= gnt[1] ? M1 : M0;
  end
`else
  // Pointer pinned to m0 makes the grant block resolve every tie in favour of m1
  assign last_gnt = M0;
`endif

  // Response is cancelled combinationally by flush or reset in its own cycle
  assign m0_rvalid = (state == RD_M0) & ~flush & ~rst;
  assign m1_rvalid = (state == RD_M1) & ~flush & ~rst;
  assign m0_rdata  = m0_rvalid ? sram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? sram_rdata : '0;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width (a multiple of 8).
REQ-002 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 flush  in  1  pipeline flush; discards an in-flight response and suppresses grants in this cycle.
REQ-005 m0_req / m1_req  in  1  request from instruction port (m0) / data port (m1).
REQ-006 m0_wen / m1_wen  in  DATA_W/8  byte write enables; all zero means read.
REQ-007 m0_addr / m1_addr  in  ADDR_W  byte address.
REQ-008 m0_wdata / m1_wdata  in  DATA_W  write data.
REQ-009 m0_gnt / m1_gnt  out  1  request accepted this cycle.
REQ-010 m0_rvalid / m1_rvalid  out  1  read data valid.
REQ-011 m0_rdata / m1_rdata  out  DATA_W  read data.
REQ-012 sram_en  out  1  SRAM access strobe.
REQ-013 sram_wen  out  DATA_W/8  SRAM byte write enables.
REQ-014 sram_addr  out  ADDR_W  SRAM address.
REQ-015 sram_wdata  out  DATA_W  SRAM write data.
REQ-016 sram_rdata  in  DATA_W  SRAM read data, valid one cycle after a read strobe.
REQ-017 stallreq  out  1  pipeline stall request.

Function
REQ-018 At most one gnt SHALL be high per cycle; sram_en SHALL equal m0_gnt|m1_gnt.
REQ-019 sram_wen/addr/wdata SHALL be combinationally muxed from the granted master; when no master is granted, sram_wen SHALL be 0.
REQ-020 A master not granted SHALL hold its req, wen, addr and wdata stable until granted; the arbiter SHALL NOT rely on re-issue.
REQ-021 FSM states SHALL be IDLE (no read outstanding), RD_M0 (m0 read outstanding) and RD_M1 (m1 read outstanding); a granted read SHALL enter RD_Mx; otherwise the FSM SHALL enter IDLE.
REQ-022 In RD_Mx, mx_rvalid SHALL be high for exactly one cycle with mx_rdata=sram_rdata; the rdata of the other master SHALL read as 0.
REQ-023 Back-to-back reads SHALL be fully pipelined: a new grant is allowed in any RD_x state, so throughput is one access per cycle.
REQ-024 Writes SHALL complete in the grant cycle and SHALL produce no rvalid.
REQ-025 stallreq SHALL equal (m0_req&!m0_gnt)|(m1_req&!m1_gnt).
REQ-026 When flush is high, no gnt SHALL be issued, the FSM SHALL go to IDLE, and any rvalid due in that cycle SHALL be suppressed.
REQ-027 With a single requester and no flush, the grant SHALL be given in the same cycle as the request (zero-cycle arbitration latency).

Reset
REQ-028 While rst is high, all gnt, rvalid and sram_en SHALL be 0, rdata SHALL be 0, and sram_wen SHALL be 0.
REQ-029 Reset SHALL force the FSM to IDLE, discard any outstanding read, and set the last-granted pointer to m0.
REQ-030 Reset SHALL take priority over flush.

Configuration
REQ-031 Macro SRAM_ARB_RR_EN defined: on contention, the master not granted last SHALL win, and the last-granted pointer SHALL update on every grant.
REQ-032 Macro SRAM_ARB_RR_EN undefined: on contention, m1 SHALL always win (fixed priority), and the pointer logic SHALL be absent.

Structure
REQ-033 FSM state encoding and master index constants SHALL live in the shared package with the other pipeline definitions.
REQ-034 The pure-combinational grant logic SHALL be a sub-module arb_grant2 (inputs: two reqs, pointer, flush; output: grant vector).

Verification
REQ-035 m0 read only, addr 0x100, SRAM word 0xDEADBEEF -> m0_gnt in cycle 0; m0_rvalid=1 with m0_rdata=0xDEADBEEF in cycle 1; stallreq=0 throughout.
REQ-036 m0 and m1 reads requested together and held -> m1 granted first in both builds; m0 granted the next cycle; stallreq=1 for exactly one cycle.
REQ-037 Build with SRAM_ARB_RR_EN, both masters requesting continuously for 6 cycles -> grants alternate m1,m0,m1,m0,m1,m0.
REQ-038 Build without SRAM_ARB_RR_EN, same stimulus -> m1 granted all 6 cycles; m0 stalled.
REQ-039 m1 write, wen=4'b0011, addr 0x200, wdata 0x0000ABCD -> sram_wen=0011 for one cycle; no rvalid; a later read of 0x200 returns low half 0xABCD.
REQ-040 m1 read granted, then flush in the next cycle -> m1_rvalid stays 0 and no gnt is issued; rst asserted while a read is outstanding -> no rvalid, and all outputs are 0 the next cycle.
